// File: rtl/qupls_rt_commit_queue.sv
// Commit-side destination mapper and in-order write buffer feeding the
// architectural register file, with a newest-match bypass for queued values.
module qupls_rt_commit_queue #(
   parameter int DEPTH = 8,
   parameter int DW    = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cm_valid,
   output logic                     cm_ready,
   input  logic [1:0]               cm_om,
   input  logic                     cm_regx,
   input  logic [8:0]               cm_aRt,
   input  logic [DW-1:0]            cm_val,
   output logic                     wr_valid,
   input  logic                     wr_ready,
   output logic [8:0]               wr_arn,
   output logic [DW-1:0]            wr_val,
   input  logic [8:0]               q_arn,
   output logic                     q_hit,
   output logic [DW-1:0]            q_val,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic [15:0]              drop_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] head_reg;
   logic [AW-1:0] tail_reg;
   logic [CW-1:0] count_reg;
   logic [15:0]   drop_reg;

   logic [8:0]    arn_mem [DEPTH];
   logic [DW-1:0] val_mem [DEPTH];

   logic [8:0]    map_base;
   logic [8:0]    map_arn;
   logic          accept;
   logic          enq;
   logic          drop;
   logic          deq;

   // Register extension first, then fold r63 onto the per-mode stack pointer.
   always_comb begin
      map_base = cm_regx ? (cm_aRt | 9'd64) : cm_aRt;
      map_arn  = map_base;
      if (map_base == 9'd63)
         map_arn = 9'd65 + {7'd0, cm_om};
   end

   assign cm_ready = (count_reg != CW'(DEPTH));
   assign accept   = cm_valid && cm_ready;
   assign enq      = accept && (map_arn != 9'd0);
   assign drop     = accept && (map_arn == 9'd0);

   assign empty    = (count_reg == '0);
   assign wr_valid = !empty;
   assign deq      = wr_valid && wr_ready;
   assign wr_arn   = wr_valid ? arn_mem[head_reg] : 9'd0;
   assign wr_val   = wr_valid ? val_mem[head_reg] : '0;
   assign count    = count_reg;
   assign drop_cnt = drop_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         count_reg <= '0;
         drop_reg  <= '0;
      end else begin
         if (enq)
            tail_reg <= tail_reg + AW'(1);
         if (deq)
            head_reg <= head_reg + AW'(1);
         case ({enq, deq})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase
         if (drop && (drop_reg != 16'hFFFF))
            drop_reg <= drop_reg + 16'd1;
      end
   end

   // Storage carries no reset; occupancy alone decides which slots are live.
   always_ff @(posedge clk) begin
      if (enq) begin
         arn_mem[tail_reg] <= map_arn;
         val_mem[tail_reg] <= cm_val;
      end
   end

   logic [DEPTH-1:0] match;
   logic [AW-1:0]    slot_idx [DEPTH];

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_scan
         // Slot gi is the gi-th oldest live entry counted from head.
         assign slot_idx[gi] = head_reg + AW'(gi);
         assign match[gi]    = (CW'(gi) < count_reg) && (arn_mem[slot_idx[gi]] == q_arn);
      end
   endgenerate

   // Later matches overwrite earlier ones, so the newest entry wins.
   always_comb begin
      q_hit = 1'b0;
      q_val = '0;
      if (q_arn != 9'd0) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
               q_hit = 1'b1;
               q_val = val_mem[slot_idx[i]];
            end
         end
      end
   end

endmodule
